mem_sched: RTL and testbench

In-order load/store scheduling queue between the issue stage and `fu_mem`. It buffers memory packets and issues one at a time into `fu_mem` whenever the unit is not busy. A store is held at the queue head until it becomes the oldest ROB entry. On `flush` it drops all buffered packets.

---
 rtl/mem_sched.sv | 139 +++++++++++++
 tb/tb_mem_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_sched.sv
// In-order load/store scheduling queue feeding fu_mem; stores wait at the head for the ROB.
// Optional perf counters enabled by defining MEM_SCHED_PERF_EN.

package mem_sched_pkg;
   localparam int unsigned XLEN          = 32;
   localparam int unsigned OFFSET_W      = 12;
   localparam int unsigned PKT_ROB_TAG_W = 5;

   typedef enum logic {IS_LOAD = 1'b0, IS_STORE = 1'b1} ls_e;

   typedef struct packed {
      logic                     valid;
      ls_e                      ls;
      logic [PKT_ROB_TAG_W-1:0] rob_tag;
      logic [XLEN-1:0]          rs1_v;
      logic [XLEN-1:0]          rs2_v;
      logic [OFFSET_W-1:0]      offset;
   } fu_pkt_t;
endpackage

module mem_sched
   import mem_sched_pkg::*;
#(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned ROB_TAG_W = PKT_ROB_TAG_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         enq_valid,
   input  fu_pkt_t                      enq_pkt,
   output logic                         enq_ready,
   input  logic [ROB_TAG_W-1:0]         rob_head_tag,
   input  logic                         fu_busy,
   output fu_pkt_t                      issue_pkt,
   output logic [$clog2(DEPTH):0]       count,
   output logic [31:0]                  perf_issue_cnt,
   output logic [31:0]                  perf_store_wait_cnt
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {EMPTY, LOAD_RDY, ST_WAIT, ST_RDY} state_e;

   state_e            state, state_nxt, cur_state_c;
   fu_pkt_t           mem [DEPTH];
   logic [PTR_W-1:0]  head, tail, head_nxt;
   logic [CNT_W-1:0]  cnt_after_deq, count_nxt;
   fu_pkt_t           head_pkt_c, next_head_pkt;
   logic              full_c, enq_fire_c, deq_c;

   function automatic state_e classify(input fu_pkt_t p, input logic [ROB_TAG_W-1:0] tag);
      if (p.ls == IS_LOAD)
         return LOAD_RDY;
      return (p.rob_tag == tag) ? ST_RDY : ST_WAIT;
   endfunction

   assign full_c     = (count == CNT_W'(DEPTH));
   assign enq_ready  = !full_c;
   assign enq_fire_c = enq_valid && !full_c && !flush;
   assign head_pkt_c = mem[head];

   // Store readiness follows rob_head_tag in the same cycle it changes.
   always_comb begin
      cur_state_c = state;
      if (state == ST_WAIT || state == ST_RDY)
         cur_state_c = (head_pkt_c.rob_tag == rob_head_tag) ? ST_RDY : ST_WAIT;
   end

   assign deq_c = (cur_state_c == LOAD_RDY || cur_state_c == ST_RDY) && !fu_busy && !flush;

   always_comb begin
      issue_pkt = '0;
      if (deq_c) begin
         issue_pkt       = head_pkt_c;
         issue_pkt.valid = 1'b1;
      end
   end

   // Next head state is derived from the entry that will sit at the head after this edge.
   always_comb begin
      cnt_after_deq = count - CNT_W'(deq_c);
      count_nxt     = cnt_after_deq + CNT_W'(enq_fire_c);
      head_nxt      = head + PTR_W'(deq_c);
      next_head_pkt = (cnt_after_deq == '0) ? enq_pkt : mem[head_nxt];
      state_nxt     = EMPTY;
      if (!flush && count_nxt != '0)
         state_nxt = classify(next_head_pkt, rob_head_tag);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= EMPTY;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= EMPTY;
      end else begin
         head  <= head_nxt;
         tail  <= tail + PTR_W'(enq_fire_c);
         count <= count_nxt;
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (enq_fire_c)
         mem[tail] <= enq_pkt;
   end

`ifdef MEM_SCHED_PERF_EN
   logic [31:0] issue_cnt_q, wait_cnt_q;

   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issue_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         if (deq_c)
            issue_cnt_q <= issue_cnt_q + 32'd1;
         if (cur_state_c == ST_WAIT)
            wait_cnt_q <= wait_cnt_q + 32'd1;
      end
   end

   assign perf_issue_cnt      = issue_cnt_q;
   assign perf_store_wait_cnt = wait_cnt_q;
`else
   assign perf_issue_cnt      = '0;
   assign perf_store_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_sched.sv
// Scoreboard bench for mem_sched: directed scenarios plus randomized traffic vs a queue model.

module tb_mem_sched;
   import mem_sched_pkg::*;

   localparam int unsigned DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          enq_valid = 1'b0;
   fu_pkt_t       enq_pkt = '0;
   logic          enq_ready;
   logic [4:0]    rob_head_tag = '0;
   logic          fu_busy = 1'b0;
   fu_pkt_t       issue_pkt;
   logic [3:0]    count;
   logic [31:0]   perf_issue_cnt, perf_store_wait_cnt;

   mem_sched #(.DEPTH(DEPTH), .ROB_TAG_W(5)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .flush               (flush),
      .enq_valid           (enq_valid),
      .enq_pkt             (enq_pkt),
      .enq_ready           (enq_ready),
      .rob_head_tag        (rob_head_tag),
      .fu_busy             (fu_busy),
      .issue_pkt           (issue_pkt),
      .count               (count),
      .perf_issue_cnt      (perf_issue_cnt),
      .perf_store_wait_cnt (perf_store_wait_cnt)
   );

   always #5 clk = ~clk;

   int        n_tests = 0;
   int        n_fail  = 0;
   fu_pkt_t   exp_q[$];
   logic      pend_acc = 1'b0;
   logic      pend_flush = 1'b0;
   fu_pkt_t   pend_pkt = '0;
   logic      mon_en = 1'b0;
   logic [31:0] mdl_issue = '0;
   logic [31:0] mdl_wait  = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic fu_pkt_t mk(input logic st, input logic [4:0] tag);
      fu_pkt_t p;
      p.valid   = 1'b1;
      p.ls      = st ? IS_STORE : IS_LOAD;
      p.rob_tag = tag;
      p.rs1_v   = $urandom;
      p.rs2_v   = $urandom;
      p.offset  = 12'($urandom);
      return p;
   endfunction

   // Commit the model effect of the previous cycle's inputs at the clock edge.
   task automatic edge_update();
      @(posedge clk);
      if (pend_flush)
         exp_q.delete();
      else if (pend_acc)
         exp_q.push_back(pend_pkt);
   endtask

   task automatic step(input logic ev, input fu_pkt_t p, input logic [4:0] tag,
                       input logic busy, input logic fl);
      edge_update();
      #1;
      enq_valid    = ev;
      enq_pkt      = p;
      rob_head_tag = tag;
      fu_busy      = busy;
      flush        = fl;
      pend_flush   = fl;
      pend_acc     = ev && !fl && (exp_q.size() < DEPTH);
      pend_pkt     = p;
   endtask

   task automatic idle(input int n, input logic [4:0] tag, input logic busy);
      for (int i = 0; i < n; i++)
         step(1'b0, '0, tag, busy, 1'b0);
   endtask

   task automatic async_reset();
      edge_update();
      #1;
      enq_valid  = 1'b0;
      flush      = 1'b0;
      fu_busy    = 1'b1;
      pend_acc   = 1'b0;
      pend_flush = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_count", 128'(count), 128'(0));
      chk("async_rst_issue", 128'(issue_pkt), 128'(0));
      chk("async_rst_enq_ready", 128'(enq_ready), 128'(1));
      exp_q.delete();
      mdl_issue = '0;
      mdl_wait  = '0;
      @(negedge clk);
      #2;
      rst = 1'b1;
   endtask

   // Monitor: predicts eligibility from the model queue and pops on every issue.
   always @(negedge clk) begin
      if (mon_en) begin
         logic    exp_issue;
         fu_pkt_t exp;
         exp_issue = rst && exp_q.size() != 0 && !fu_busy && !flush &&
                     (exp_q[0].ls == IS_LOAD || exp_q[0].rob_tag == rob_head_tag);
         chk("count", 128'(count), 128'(exp_q.size()));
         chk("enq_ready", 128'(enq_ready), 128'(exp_q.size() < DEPTH));
`ifdef MEM_SCHED_PERF_EN
         chk("perf_issue", 128'(perf_issue_cnt), 128'(mdl_issue));
         chk("perf_store_wait", 128'(perf_store_wait_cnt), 128'(mdl_wait));
`else
         chk("perf_issue", 128'(perf_issue_cnt), 128'(0));
         chk("perf_store_wait", 128'(perf_store_wait_cnt), 128'(0));
`endif
         chk("issue_valid", 128'(issue_pkt.valid), 128'(exp_issue));
         if (issue_pkt.valid) begin
            if (exp_q.size() == 0) begin
               chk("issue_from_empty", 128'(issue_pkt), 128'(0));
            end else begin
               exp = exp_q.pop_front();
               exp.valid = 1'b1;
               chk("issue_pkt", 128'(issue_pkt), 128'(exp));
            end
         end else begin
            chk("issue_idle_zero", 128'(issue_pkt), 128'(0));
         end
         if (rst && exp_q.size() != 0 && exp_q[0].ls == IS_STORE &&
             exp_q[0].rob_tag != rob_head_tag && !exp_issue)
            mdl_wait = mdl_wait + 32'd1;
         if (exp_issue)
            mdl_issue = mdl_issue + 32'd1;
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_count", 128'(count), 128'(0));
      chk("reset_issue", 128'(issue_pkt), 128'(0));
      chk("reset_enq_ready", 128'(enq_ready), 128'(1));
      chk("reset_perf_issue", 128'(perf_issue_cnt), 128'(0));
      chk("reset_perf_wait", 128'(perf_store_wait_cnt), 128'(0));
      rst    = 1'b1;
      mon_en = 1'b1;

      // Load pass-through
      step(1'b1, mk(1'b0, 5'd3), 5'd0, 1'b0, 1'b0);
      idle(3, 5'd0, 1'b0);

      // Store gating on ROB head
      step(1'b1, mk(1'b1, 5'd5), 5'd2, 1'b0, 1'b0);
      idle(4, 5'd2, 1'b0);
      idle(3, 5'd5, 1'b0);

      // Backpressure ordering
      step(1'b1, mk(1'b0, 5'd1), 5'd0, 1'b0, 1'b0);
      step(1'b1, mk(1'b0, 5'd2), 5'd0, 1'b0, 1'b0);
      idle(3, 5'd0, 1'b1);
      idle(3, 5'd0, 1'b0);

      // Fill to full, overflow attempt, then drain with wrap
      for (int i = 0; i < 9; i++)
         step(1'b1, mk(1'b0, 5'(i)), 5'd0, 1'b1, 1'b0);
      idle(1, 5'd0, 1'b1);
      for (int i = 0; i < 6; i++)
         step(1'b1, mk(1'b0, 5'(i + 9)), 5'd0, 1'b0, 1'b0);
      idle(16, 5'd0, 1'b0);

      // Flush with same-cycle enqueue while head is eligible
      for (int i = 0; i < 5; i++)
         step(1'b1, mk(1'b0, 5'(i)), 5'd0, 1'b1, 1'b0);
      step(1'b1, mk(1'b0, 5'd30), 5'd0, 1'b0, 1'b1);
      idle(4, 5'd0, 1'b0);

      // Async reset with entries queued
      for (int i = 0; i < 3; i++)
         step(1'b1, mk(1'b1, 5'd7), 5'd0, 1'b1, 1'b0);
      async_reset();
      idle(3, 5'd0, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 99) < 60, mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3))),
              5'($urandom_range(0, 3)), $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 3);
      idle(12, 5'd0, 1'b0);
      edge_update();
      @(negedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
